instr_sequencer: RTL and testbench

Parametrised successor to the node instruction ROM: program counter plus writable instruction RAM for one TIS-100 execution node. Programs are loaded at run time, not fixed at synthesis, and the counter wraps at the loaded program length. Adds a stall input so a node blocked on a port holds its PC, and registers the opcode output. Sits between the per-node decoder/ALU (which supplies op, acc, jmp_off) and the node's instruction fetch.

---
 rtl/instr_sequencer_pkg.sv | 21 ++
 rtl/instr_sequencer_ram.sv | 27 ++
 rtl/instr_sequencer.sv | 175 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the node instruction sequencer: op codes (common with the
// per-node decoder) and the default program depth.
package instr_sequencer_pkg;

    localparam int INSTR_MAX_DEPTH = 15;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JEZ = 4'd8;
    localparam logic [3:0] OP_JNZ = 4'd9;
    localparam logic [3:0] OP_JGZ = 4'd10;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

endpackage

// File: rtl/instr_sequencer_ram.sv
// Simple dual-port instruction RAM: synchronous write on port A, synchronous read on port B.
module instr_ram #(
    parameter int DEPTH  = 15,
    parameter int WIDTH  = 21,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program counter plus run-time loadable instruction RAM for one TIS-100 execution node.
// Define INSTR_SEQ_BREAKPOINT_EN to add the single-address breakpoint (bp_en/bp_addr/resume/halted).
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH    = INSTR_MAX_DEPTH,
    parameter int OPCODE_W = 21,
    parameter int ACC_W    = 11,
    parameter int PC_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                stall,
    input  logic                wr_en,
    input  logic [PC_W-1:0]     wr_addr,
    input  logic [OPCODE_W-1:0] wr_data,
    input  logic                clear,
    input  logic [3:0]          op,
    input  logic [ACC_W-1:0]    acc,
    input  logic [ACC_W-1:0]    jmp_off,
`ifdef INSTR_SEQ_BREAKPOINT_EN
    input  logic                bp_en,
    input  logic [PC_W-1:0]     bp_addr,
    input  logic                resume,
    output logic                halted,
`endif
    output logic [OPCODE_W-1:0] opcode,
    output logic                op_valid,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W:0]       prog_len
);

    localparam int            TGT_W   = ACC_W + 1;
    localparam logic [PC_W:0] DEPTH_L = (PC_W + 1)'(DEPTH);

    logic [PC_W-1:0]         pc_q, pc_d;
    logic [PC_W:0]           len_q, len_d;
    logic                    valid_q, valid_d;
    logic [OPCODE_W-1:0]     ram_q;
    logic                    hold;
    logic                    wr_ok;
    logic [PC_W:0]           wr_len;
    logic [PC_W:0]           len_m1;
    logic [PC_W-1:0]         last_pc;
    logic                    acc_zero, acc_neg;
    logic                    jmp_en;
    logic signed [TGT_W-1:0] target, len_s;

    // Reset and clear both suppress the RAM write so a half-finished load cannot land.
    assign wr_ok   = !run && wr_en && reset && !clear && ({1'b0, wr_addr} < DEPTH_L);
    assign wr_len  = {1'b0, wr_addr} + (PC_W + 1)'(1);
    assign len_m1  = len_q - (PC_W + 1)'(1);
    assign last_pc = len_m1[PC_W-1:0];

    assign acc_zero = (acc == '0);
    assign acc_neg  = acc[ACC_W-1];

    always_comb begin
        case (op)
            OP_JMP, OP_JRO: jmp_en = 1'b1;
            OP_JEZ:         jmp_en = acc_zero;
            OP_JNZ:         jmp_en = !acc_zero;
            OP_JGZ:         jmp_en = !acc_zero && !acc_neg;
            OP_JLZ:         jmp_en = acc_neg;
            default:        jmp_en = 1'b0;
        endcase
    end

    assign target = $signed({{(TGT_W - PC_W){1'b0}}, pc_q}) + $signed({jmp_off[ACC_W-1], jmp_off});
    assign len_s  = $signed({{(TGT_W - PC_W - 1){1'b0}}, len_q});

`ifdef INSTR_SEQ_BREAKPOINT_EN
    logic halted_q, halted_d;
    logic advance;
    logic bp_skip;

    assign hold    = stall || (halted_q && !resume);
    assign advance = run && (len_q != '0) && !hold;
    // The advance that leaves a breakpoint must not re-arm on the same address.
    assign bp_skip = halted_q && resume;

    always_comb begin
        halted_d = halted_q;
        if (!run) begin
            halted_d = 1'b0;
        end else begin
            if (bp_skip) begin
                halted_d = 1'b0;
            end
            if (advance && bp_en && !bp_skip && (pc_d == bp_addr)) begin
                halted_d = 1'b1;
            end
        end
    end

    assign halted = halted_q;
`else
    assign hold = stall;
`endif

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        len_d   = len_q;
        if (!run) begin
            pc_d    = '0;
            valid_d = 1'b0;
            if (clear) begin
                len_d = '0;
            end else if (wr_ok && (wr_len > len_q)) begin
                len_d = wr_len;
            end
        end else if (len_q == '0) begin
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (!hold) begin
            valid_d = 1'b1;
            // First fetch after run rises presents word 0 before any sequencing.
            if (!valid_q) begin
                pc_d = '0;
            end else if (jmp_en) begin
                if (target[TGT_W-1]) begin
                    pc_d = '0;
                end else if (target >= len_s) begin
                    pc_d = last_pc;
                end else begin
                    pc_d = target[PC_W-1:0];
                end
            end else if (pc_q == last_pc) begin
                pc_d = '0;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
`ifdef INSTR_SEQ_BREAKPOINT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            pc_q     <= pc_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
`ifdef INSTR_SEQ_BREAKPOINT_EN
            halted_q <= halted_d;
`endif
        end
    end

    // Read address follows pc_d so the RAM output register tracks mem[pc].
    instr_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (OPCODE_W),
        .ADDR_W (PC_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc_d),
        .rd_data (ram_q)
    );

    assign opcode   = valid_q ? ram_q : '0;
    assign op_valid = valid_q;
    assign pc       = pc_q;
    assign prog_len = len_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed stimulus pushes expected state, a monitor
// pops and compares one entry after every rising edge.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int DEPTH    = 15;
    localparam int OPCODE_W = 21;
    localparam int ACC_W    = 11;
    localparam int PC_W     = 4;

    logic                clk = 1'b0;
    logic                reset, run, stall, wr_en, clear;
    logic [PC_W-1:0]     wr_addr;
    logic [OPCODE_W-1:0] wr_data;
    logic [3:0]          op;
    logic [ACC_W-1:0]    acc, jmp_off;
    logic [OPCODE_W-1:0] opcode;
    logic                op_valid;
    logic [PC_W-1:0]     pc;
    logic [PC_W:0]       prog_len;
`ifdef INSTR_SEQ_BREAKPOINT_EN
    logic                bp_en, resume, halted;
    logic [PC_W-1:0]     bp_addr;
`endif

    always #5 clk = ~clk;

    instr_sequencer #(
        .DEPTH    (DEPTH),
        .OPCODE_W (OPCODE_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .stall    (stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clear    (clear),
        .op       (op),
        .acc      (acc),
        .jmp_off  (jmp_off),
`ifdef INSTR_SEQ_BREAKPOINT_EN
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .resume   (resume),
        .halted   (halted),
`endif
        .opcode   (opcode),
        .op_valid (op_valid),
        .pc       (pc),
        .prog_len (prog_len)
    );

    typedef struct {
        string               name;
        logic [PC_W-1:0]     pc;
        logic [OPCODE_W-1:0] opcode;
        logic                v;
        logic [PC_W:0]       len;
        logic                halt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Expected state after the next rising edge; inputs must already be set.
    task automatic step(input string nm, input int epc, input int eop, input bit ev,
                        input int elen, input bit eh = 1'b0);
        exp_t e;
        e.name   = nm;
        e.pc     = PC_W'(epc);
        e.opcode = OPCODE_W'(eop);
        e.v      = ev;
        e.len    = (PC_W + 1)'(elen);
        e.halt   = eh;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic jr(input logic [3:0] o, input int a, input int j);
        op      = o;
        acc     = ACC_W'(a);
        jmp_off = ACC_W'(j);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                logic bad;
                e = sb.pop_front();
                vectors++;
                bad = (pc !== e.pc) || (opcode !== e.opcode) || (op_valid !== e.v) ||
                      (prog_len !== e.len);
`ifdef INSTR_SEQ_BREAKPOINT_EN
                bad = bad || (halted !== e.halt);
`endif
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s: got pc=%0d opcode=%h valid=%b len=%0d, want pc=%0d opcode=%h valid=%b len=%0d halt=%b",
                             e.name, pc, opcode, op_valid, prog_len,
                             e.pc, e.opcode, e.v, e.len, e.halt);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; run = 1'b0; stall = 1'b0; wr_en = 1'b0; clear = 1'b0;
        wr_addr = '0; wr_data = '0;
        jr(OP_NOP, 0, 0);
`ifdef INSTR_SEQ_BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = '0; resume = 1'b0;
`endif
        step("reset0", 0, 0, 0, 0);
        step("reset1", 0, 0, 0, 0);

        reset = 1'b1; wr_en = 1'b1;
        wr_addr = 4'd0;  wr_data = 21'h11; step("load0", 0, 0, 0, 1);
        wr_addr = 4'd1;  wr_data = 21'h22; step("load1", 0, 0, 0, 2);
        wr_addr = 4'd2;  wr_data = 21'h33; step("load2", 0, 0, 0, 3);
        wr_addr = 4'd3;  wr_data = 21'h44; step("load3", 0, 0, 0, 4);
        wr_addr = 4'd15; wr_data = 21'h07; step("load_oob", 0, 0, 0, 4);
        wr_addr = 4'd1;  wr_data = 21'h22; step("load_rewrite", 0, 0, 0, 4);

        wr_en = 1'b0; run = 1'b1;
        step("run_first", 0, 'h11, 1, 4);
        step("run_pc1", 1, 'h22, 1, 4);
        step("run_pc2", 2, 'h33, 1, 4);
        step("run_pc3", 3, 'h44, 1, 4);
        step("run_wrap", 0, 'h11, 1, 4);
        step("adv1", 1, 'h22, 1, 4);
        jr(OP_JRO, 0, -5);     step("jro_neg_clamp", 0, 'h11, 1, 4);
        jr(OP_NOP, 0, 0);      step("adv1b", 1, 'h22, 1, 4);
        jr(OP_JRO, 0, 9);      step("jro_pos_clamp", 3, 'h44, 1, 4);
        jr(OP_NOP, 0, 0);      step("wrap2", 0, 'h11, 1, 4);
        step("adv1c", 1, 'h22, 1, 4);
        step("adv2", 2, 'h33, 1, 4);
        jr(OP_JGZ, -1, -2);    step("jgz_not", 3, 'h44, 1, 4);
        jr(OP_NOP, 0, 0);      step("wrap3", 0, 'h11, 1, 4);
        step("adv1d", 1, 'h22, 1, 4);
        step("adv2b", 2, 'h33, 1, 4);
        jr(OP_JGZ, 7, -2);     step("jgz_taken", 0, 'h11, 1, 4);
        jr(OP_JEZ, 0, 2);      step("jez_taken", 2, 'h33, 1, 4);
        jr(OP_JEZ, -1024, -2); step("jez_not", 3, 'h44, 1, 4);
        jr(OP_JNZ, -1024, -2); step("jnz_taken", 1, 'h22, 1, 4);
        jr(OP_JNZ, 0, 1);      step("jnz_not", 2, 'h33, 1, 4);
        jr(OP_JLZ, -1024, 1);  step("jlz_taken", 3, 'h44, 1, 4);
        jr(OP_JLZ, 0, -3);     step("jlz_not_wrap", 0, 'h11, 1, 4);
        jr(OP_JMP, 0, 2);      step("jmp", 2, 'h33, 1, 4);

        jr(OP_JMP, 0, 1); stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall_hold", 2, 'h33, 1, 4);
        stall = 1'b0;          step("stall_release", 3, 'h44, 1, 4);
        jr(OP_JMP, 0, -1024);  step("jmp_min", 0, 'h11, 1, 4);
        jr(OP_JMP, 0, 1023);   step("jmp_max", 3, 'h44, 1, 4);

        jr(OP_NOP, 0, 0); run = 1'b0; step("run_fall", 0, 0, 0, 4);
        run = 1'b1;            step("restart", 0, 'h11, 1, 4);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 21'h55; clear = 1'b1;
        step("wr_in_run", 1, 'h22, 1, 4);
        wr_en = 1'b0; clear = 1'b0;
        step("adv2c", 2, 'h33, 1, 4);
        step("adv3c", 3, 'h44, 1, 4);
        step("ram_kept", 0, 'h11, 1, 4);

        run = 1'b0;            step("load_mode", 0, 0, 0, 4);
        clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 21'h66;
        step("clear_wins", 0, 0, 0, 0);
        clear = 1'b0; wr_en = 1'b0; run = 1'b1;
        step("empty0", 0, 0, 0, 0);
        step("empty1", 0, 0, 0, 0);

        run = 1'b0; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 21'h99;
        step("load_len1", 0, 0, 0, 1);
        wr_en = 1'b0; run = 1'b1;
        step("len1_first", 0, 'h99, 1, 1);
        step("len1_nop", 0, 'h99, 1, 1);
        jr(OP_JMP, 0, 5);      step("len1_jmp", 0, 'h99, 1, 1);
        jr(OP_JRO, 0, -3);     step("len1_jro", 0, 'h99, 1, 1);

        jr(OP_NOP, 0, 0); run = 1'b0; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 21'h77;
        reset = 1'b0;          step("reset_load", 0, 0, 0, 0);
        reset = 1'b1; wr_addr = 4'd1; wr_data = 21'hA1;
        step("reload", 0, 0, 0, 2);
        wr_en = 1'b0; run = 1'b1;
        step("rerun0", 0, 'h99, 1, 2);
        step("rerun1", 1, 'hA1, 1, 2);
        reset = 1'b0;          step("reset_run", 0, 0, 0, 0);
        reset = 1'b1;          step("after_reset_empty", 0, 0, 0, 0);

`ifdef INSTR_SEQ_BREAKPOINT_EN
        run = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 21'h44;
        step("bp_load", 0, 0, 0, 4, 0);
        wr_en = 1'b0; bp_en = 1'b1; bp_addr = 4'd2; run = 1'b1;
        step("bp_start", 0, 'h99, 1, 4, 0);
        step("bp_pc1", 1, 'hA1, 1, 4, 0);
        step("bp_hit", 2, 'h33, 1, 4, 1);
        step("bp_held", 2, 'h33, 1, 4, 1);
        resume = 1'b1;         step("bp_resume", 3, 'h44, 1, 4, 0);
        resume = 1'b0;         step("bp_after", 0, 'h99, 1, 4, 0);
        run = 1'b0; bp_en = 1'b0;
        step("bp_off", 0, 0, 0, 4, 0);
`endif

        @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
